// File: rtl/msi_bus_responder_if.sv
// msi_bus_responder_if: two-core request/response, broadcast and snoop signals of the shared MSI bus
// Core side (master): req/cmd/addr/wdata and snoop_flush/snoop_data out; gnt/done/rdata and bus_* in.
// Responder side (slave): the mirror image, plus busy.
interface msi_bus_responder_if #(
  parameter int ADDR_BITS = 11,
  parameter int DATA_BITS = 16
);
  logic                 req_0, req_1;
  logic [2:0]           cmd_0, cmd_1;
  logic [ADDR_BITS-1:0] addr_0, addr_1;
  logic [DATA_BITS-1:0] wdata_0, wdata_1;
  logic                 gnt_0, gnt_1;
  logic                 done_0, done_1;
  logic [DATA_BITS-1:0] rdata_0, rdata_1;
  logic [2:0]           bus_cmd;
  logic [ADDR_BITS-1:0] bus_addr;
  logic [DATA_BITS-1:0] bus_data;
  logic                 snoop_flush_0, snoop_flush_1;
  logic [DATA_BITS-1:0] snoop_data_0, snoop_data_1;
  logic                 busy;
  modport master (
    output req_0, req_1, cmd_0, cmd_1, addr_0, addr_1, wdata_0, wdata_1,
    output snoop_flush_0, snoop_flush_1, snoop_data_0, snoop_data_1,
    input  gnt_0, gnt_1, done_0, done_1, rdata_0, rdata_1,
    input  bus_cmd, bus_addr, bus_data, busy
  );
  modport slave (
    input  req_0, req_1, cmd_0, cmd_1, addr_0, addr_1, wdata_0, wdata_1,
    input  snoop_flush_0, snoop_flush_1, snoop_data_0, snoop_data_1,
    output gnt_0, gnt_1, done_0, done_1, rdata_0, rdata_1,
    output bus_cmd, bus_addr, bus_data, busy
  );
endinterface

// File: rtl/msi_bus_responder.sv
// msi_bus_responder: round-robin bus arbiter and main-memory responder for a two-core MSI system
// Ports: clk, rst (async, active-high); b = slave side of msi_bus_responder_if carrying both
// cores' requests/completions, the snoop broadcast (bus_cmd/addr/data), snoop flushes and busy.
module msi_bus_responder #(
  parameter int                   ADDR_BITS   = 11,
  parameter int                   DATA_BITS   = 16,
  parameter int                   MEM_LATENCY = 4,
  parameter logic [DATA_BITS-1:0] MEM_INIT    = '0
) (
  input logic clk,
  input logic rst,
  msi_bus_responder_if.slave b
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BCAST, MEM, RESP} state_t;
  state_t               state_q, state_d;
  logic                 rr_q, rr_d, id_q, id_d;
  logic [2:0]           cmd_q, cmd_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d, resp_q, resp_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  // Power-up contents only; rst deliberately leaves memory untouched.
  logic [DATA_BITS-1:0] mem [2**ADDR_BITS] = '{default: MEM_INIT};
  logic                 v0, v1, pick1, wr, flush, we, d0, d1;
  logic [DATA_BITS-1:0] mem_wd;
  assign v0 = b.req_0 && b.cmd_0 != 3'd0;
  assign v1 = b.req_1 && b.cmd_1 != 3'd0;
  // Core 1 wins when alone, or on a tie when core 0 was the last tie winner.
  assign pick1 = v1 && (!v0 || !rr_q);
  assign wr = cmd_q == 3'd3 || cmd_q == 3'd4;
  // Only the non-requesting core may flush; the requester's own flush line is ignored.
  assign flush = id_q ? b.snoop_flush_0 : b.snoop_flush_1;
  assign mem_wd = wr ? wdata_q : (id_q ? b.snoop_data_0 : b.snoop_data_1);
  assign we = state_q == BCAST && (wr || flush);
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (v0 || v1) begin
        state_d = BCAST;
        id_d    = pick1;
        rr_d    = v0 && v1 ? pick1 : rr_q;
        cmd_d   = pick1 ? b.cmd_1 : b.cmd_0;
        addr_d  = pick1 ? b.addr_1 : b.addr_0;
        wdata_d = pick1 ? b.wdata_1 : b.wdata_0;
      end
      BCAST: begin
        state_d = wr || flush ? RESP : MEM;
        resp_d  = mem_wd;
        cnt_d   = CW'(MEM_LATENCY - 1);
      end
      MEM: begin
        cnt_d   = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? RESP : MEM;
        resp_d  = cnt_q == '0 ? mem[addr_q] : resp_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b1;
      id_q    <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[addr_q] <= mem_wd;
  end
  assign d0         = state_q == RESP && !id_q;
  assign d1         = state_q == RESP && id_q;
  assign b.gnt_0    = state_q != IDLE && !id_q;
  assign b.gnt_1    = state_q != IDLE && id_q;
  assign b.done_0   = d0;
  assign b.done_1   = d1;
  assign b.rdata_0  = d0 ? resp_q : '0;
  assign b.rdata_1  = d1 ? resp_q : '0;
  assign b.bus_cmd  = state_q == BCAST ? cmd_q : 3'd0;
  assign b.bus_addr = state_q == BCAST ? addr_q : '0;
  assign b.bus_data = state_q == BCAST && wr ? wdata_q : '0;
  assign b.busy     = state_q != IDLE;
endmodule

// File: tb/tb_msi_bus_responder.sv
// tb_msi_bus_responder: directed stimulus with per-core expected-response queues checked by a done monitor
module tb_msi_bus_responder;
  localparam int L = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  msi_bus_responder_if #(.ADDR_BITS(11), .DATA_BITS(16)) b();
  msi_bus_responder #(.ADDR_BITS(11), .DATA_BITS(16), .MEM_LATENCY(L), .MEM_INIT(16'h0000)) dut (
    .clk(clk),
    .rst(rst),
    .b(b.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // Monitor: every done pulse must match the oldest expectation for that core.
  always @(negedge clk) begin
    if (b.done_0) begin
      if (q0.size() == 0) chk("unexpected_done_0", 1, 0);
      else chk("rdata_0", b.rdata_0, q0.pop_front());
      chk("rdata_1_quiet", b.rdata_1, 0);
    end
    if (b.done_1) begin
      if (q1.size() == 0) chk("unexpected_done_1", 1, 0);
      else chk("rdata_1", b.rdata_1, q1.pop_front());
      chk("rdata_0_quiet", b.rdata_0, 0);
    end
  end
  task automatic drive(input bit id, input logic r, input logic [2:0] c, input logic [10:0] a, input logic [15:0] d);
    if (id) begin
      b.req_1 = r; b.cmd_1 = c; b.addr_1 = a; b.wdata_1 = d;
    end else begin
      b.req_0 = r; b.cmd_0 = c; b.addr_0 = a; b.wdata_0 = d;
    end
  endtask
  // Issue one request, check its broadcast and (if lat>0) the cycles from request to done.
  task automatic xact(input bit id, input logic [2:0] c, input logic [10:0] a, input logic [15:0] d,
                      input logic [15:0] exp, input int lat, output int t_done);
    int n = 0;
    bit bc = 0;
    bit got = 0;
    if (id) q1.push_back(exp); else q0.push_back(exp);
    @(negedge clk);
    drive(id, 1'b1, c, a, d);
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      if ((id ? b.gnt_1 : b.gnt_0) && b.bus_cmd != 3'd0 && !bc) begin
        bc = 1;
        chk("bus_cmd", b.bus_cmd, c);
        chk("bus_addr", b.bus_addr, a);
        chk("bus_data", b.bus_data, (c == 3'd3 || c == 3'd4) ? d : 16'h0);
      end
      got = id ? b.done_1 : b.done_0;
      if (got) chk("gnt_in_resp", id ? b.gnt_1 : b.gnt_0, 1);
    end
    t_done = cyc;
    if (!got) chk("done_timeout", 0, 1);
    else begin
      chk("bcast_seen", bc, 1);
      if (lat > 0) chk("latency", n, lat);
    end
    drive(id, 1'b0, 3'd0, 11'h0, 16'h0);
  endtask
  initial begin
    int t0, t1, tx;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    b.snoop_flush_0 = 0; b.snoop_flush_1 = 0;
    b.snoop_data_0 = 0; b.snoop_data_1 = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(|{b.gnt_0, b.gnt_1, b.done_0, b.done_1, b.rdata_0, b.rdata_1,
                               b.bus_cmd, b.bus_addr, b.bus_data, b.busy}), 0);
    rst = 0;
    // 1: cold miss from memory
    xact(0, 3'd1, 11'h040, 16'h0, 16'h0000, L + 2, tx);
    // 2: update then read by the other core
    xact(0, 3'd3, 11'h040, 16'hABCD, 16'hABCD, 2, tx);
    xact(1, 3'd1, 11'h040, 16'h0, 16'hABCD, L + 2, tx);
    // 3: other-core flush bypasses memory and is written back
    b.snoop_flush_0 = 1; b.snoop_data_0 = 16'h5678;
    xact(1, 3'd1, 11'h0C0, 16'h0, 16'h5678, 2, tx);
    b.snoop_data_0 = 16'h9999;
    xact(0, 3'd1, 11'h0C0, 16'h0, 16'h5678, L + 2, tx);
    b.snoop_flush_0 = 0; b.snoop_data_0 = 0;
    // 4: simultaneous updates, round-robin rotation
    fork
      xact(0, 3'd3, 11'h400, 16'hDEAD, 16'hDEAD, 0, t0);
      xact(1, 3'd3, 11'h400, 16'hBEEF, 16'hBEEF, 0, t1);
    join
    chk("rr_core0_first", 32'(t0 < t1), 1);
    xact(0, 3'd1, 11'h400, 16'h0, 16'hBEEF, L + 2, tx);
    fork
      xact(0, 3'd3, 11'h400, 16'h1111, 16'h1111, 0, t0);
      xact(1, 3'd3, 11'h400, 16'h2222, 16'h2222, 0, t1);
    join
    chk("rr_core1_first", 32'(t1 < t0), 1);
    xact(1, 3'd1, 11'h400, 16'h0, 16'h1111, L + 2, tx);
    // 5: reset during MEM aborts silently
    @(negedge clk);
    drive(0, 1, 3'd1, 11'h100, 16'h0);
    repeat (3) @(negedge clk);
    chk("busy_in_mem", b.busy, 1);
    #1 rst = 1;
    #1 chk("abort_outputs", 32'(|{b.gnt_0, b.gnt_1, b.done_0, b.done_1, b.rdata_0, b.rdata_1,
                                  b.bus_cmd, b.bus_addr, b.bus_data, b.busy}), 0);
    drive(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    xact(0, 3'd1, 11'h100, 16'h0, 16'h0000, L + 2, tx);
    // 6: top address, no wrap to address 0
    xact(0, 3'd4, 11'h7FF, 16'h1234, 16'h1234, 2, tx);
    xact(0, 3'd2, 11'h7FF, 16'h0, 16'h1234, L + 2, tx);
    xact(1, 3'd1, 11'h000, 16'h0, 16'h0000, L + 2, tx);
    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/msi_bus_responder.md
Name: msi_bus_responder

Overview:
Shared-bus arbiter and main-memory responder for the two-core MSI cache system; it is the target end of the requests the per-core cache controllers issue.
- Grants one core's bus request at a time, round-robin.
- Broadcasts the winning transaction on the universal bus so the other core can snoop.
- Services the request from a snooping owner's flush, or from word-addressed main memory after a fixed latency.
- Sits between the two cache controllers and backing memory inside dual_core_cache_system.

Parameters:
ADDR_BITS, 11, address width (word address).
DATA_BITS, 16, data word width.
MEM_LATENCY, 4, cycles in MEM state for a memory read (minimum 1).
MEM_INIT, 0, reset/initial value of every memory word.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req_0  in  1  core 0 bus request, held until done_0.
cmd_0  in  3  core 0 command: 0 IDLE, 1 BUS_RD, 2 BUS_RDX, 3 BUS_UPD, 4 FLUSH.
addr_0  in  ADDR_BITS  core 0 address.
wdata_0  in  DATA_BITS  core 0 write/flush data.
gnt_0  out  1  core 0 owns bus (BCAST through RESP).
done_0  out  1  one-cycle completion pulse for core 0.
rdata_0  out  DATA_BITS  read data to core 0, valid with done_0.
req_1, cmd_1, addr_1, wdata_1, gnt_1, done_1, rdata_1: same as core 0, for core 1.
bus_cmd  out  3  broadcast command; 0 when idle.
bus_addr  out  ADDR_BITS  broadcast address.
bus_data  out  DATA_BITS  broadcast data (write data for BUS_UPD/FLUSH, else 0).
snoop_flush_0  in  1  core 0 holds the line in M and supplies data (valid in BCAST).
snoop_flush_1  in  1  core 1 snoop flush.
snoop_data_0  in  DATA_BITS  core 0 flushed data.
snoop_data_1  in  DATA_BITS  core 1 flushed data.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset:
  - FSM to IDLE; rr_last = 1, so core 0 wins the first tie.
  - All outputs are 0.
  - Memory is not cleared by rst; it is initialised to MEM_INIT only at time zero.
- Reset mid-transaction aborts it with no done pulse and no memory write.
- States are IDLE, BCAST, MEM, RESP.
- IDLE:
  - Requests with cmd=IDLE are ignored.
  - With a single valid request, that core is granted.
  - With both valid, the core != rr_last is granted and rr_last becomes the winner.
  - The request is latched (cmd, addr, wdata, id); go to BCAST next cycle.
  - Latched values are stable regardless of input changes after the grant.
- BCAST (1 cycle):
  - bus_cmd/bus_addr/bus_data are driven from latched values; gnt_<id>=1.
  - The snoop flush of the non-requesting core only is sampled; the requester's own snoop_flush is ignored.
  - BUS_RD or BUS_RDX with other-core flush: the flushed data is latched as the response and written to memory at addr this cycle; go to RESP (memory is bypassed).
  - BUS_RD or BUS_RDX without flush: go to MEM with counter = MEM_LATENCY-1.
  - BUS_UPD or FLUSH: write wdata to memory this cycle; the response data is wdata; go to RESP.
- MEM:
  - Decrement the counter; when it is 0, latch mem[addr] as the response and go to RESP.
  - Total BUS_RD miss latency is grant-cycle + 1 BCAST + MEM_LATENCY + 1 RESP.
- RESP (1 cycle):
  - done_<id>=1 and rdata_<id>=response data; the other core's done and rdata are 0.
  - Go to IDLE; a new grant is possible on the next cycle, and back-to-back requests incur one IDLE cycle.
- gnt is held continuously from BCAST through RESP, and is 0 in IDLE.
- A write and a read to the same address in sequence: the read returns the newly written value (write-first ordering).
- Address wrap-around: none; all 2^ADDR_BITS words are addressable, and the full address is used with no offset stripping.
- If snoop_flush asserts outside BCAST, it is ignored.

Test Plan:
1. Reset, then core 0 BUS_RD addr 0x040 with memory = 0 → done_0 pulses exactly MEM_LATENCY+2 cycles after the grant with rdata_0=0x0000; bus_cmd=1 and bus_addr=0x040 during BCAST.
2. Core 0 BUS_UPD 0x040 data 0xABCD, then core 1 BUS_RD 0x040 → bus_data=0xABCD in BCAST; core 1 rdata_1=0xABCD.
3. Core 1 BUS_RD 0x0C0 with snoop_flush_0=1 and snoop_data_0=0x5678 in BCAST → no MEM state; done_1 two cycles after the grant with rdata_1=0x5678; a later core 0 BUS_RD 0x0C0 from memory returns 0x5678.
4. Both cores request BUS_UPD 0x400 (core 0 0xDEAD, core 1 0xBEEF) in the same cycle → core 0 is served first and core 1 second; a subsequent BUS_RD 0x400 returns 0xBEEF. Repeat the simultaneous pair → core 1 is served first this time (rotation).
5. Assert rst during MEM of a BUS_RD → all outputs are 0 immediately, no done pulse, FSM is IDLE; a new request completes normally.
6. Core 0 FLUSH 0x7FF data 0x1234, then BUS_RDX 0x7FF → rdata_0=0x1234 (top address accessible, no wrap).
